// File: rtl/stream_bytes_to_apb.sv
// Byte-stream to APB3 bridge: big-endian address bytes, little-endian data words, auto-increment.
// Optional PSLVERR handling and sticky err are enabled by defining STREAM_APB_PSLVERR_EN.
module stream_bytes_to_apb #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_BYTES = 1,
    parameter int AUTO_INC   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    output logic [7:0]              out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    input  logic                    busy,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [8*DATA_BYTES-1:0] PWDATA,
    input  logic [8*DATA_BYTES-1:0] PRDATA,
    input  logic                    PREADY,
`ifdef STREAM_APB_PSLVERR_EN
    input  logic                    PSLVERR,
`endif
    output logic                    err
);

    localparam int AB  = (ADDR_WIDTH + 7) / 8;
    localparam int AW8 = 8 * AB;
    localparam int DW  = 8 * DATA_BYTES;
    localparam logic [7:0] AB_C    = 8'(AB);
    localparam logic [7:0] DB_LAST = 8'(DATA_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_SETUP,
        S_ACCESS,
        S_RSEND
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [AW8-1:0]        ash_q, ash_d;
    logic [7:0]            acnt_q, acnt_d;
    logic [7:0]            wcnt_q, wcnt_d;
    logic [7:0]            rcnt_q, rcnt_d;
    logic [DW-1:0]         pwdata_q, pwdata_d;
    logic [DW-1:0]         rdata_q, rdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  addr_valid_q, addr_valid_d;
    logic                  abort_q, abort_d;
    logic                  busy_q;

    logic busy_fall;
    logic in_fire;
    logic perr;
    logic aborting;
    logic unused_in_last;

    assign busy_fall      = busy_q & ~busy;
    assign in_fire        = in_valid & in_ready;
    assign unused_in_last = in_last;

`ifdef STREAM_APB_PSLVERR_EN
    logic err_q;

    assign perr = PSLVERR;
    assign err  = err_q;

    // A fresh address phase starts a clean error window
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == S_IDLE && in_fire && !busy_fall) begin
            err_q <= 1'b0;
        end else if (state_q == S_ACCESS && PREADY && PSLVERR) begin
            err_q <= 1'b1;
        end
    end
`else
    assign perr = 1'b0;
    assign err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            paddr_q      <= '0;
            ash_q        <= '0;
            acnt_q       <= '0;
            wcnt_q       <= '0;
            rcnt_q       <= '0;
            pwdata_q     <= '0;
            rdata_q      <= '0;
            pwrite_q     <= 1'b0;
            addr_valid_q <= 1'b0;
            abort_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            paddr_q      <= paddr_d;
            ash_q        <= ash_d;
            acnt_q       <= acnt_d;
            wcnt_q       <= wcnt_d;
            rcnt_q       <= rcnt_d;
            pwdata_q     <= pwdata_d;
            rdata_q      <= rdata_d;
            pwrite_q     <= pwrite_d;
            addr_valid_q <= addr_valid_d;
            abort_q      <= abort_d;
            busy_q       <= busy;
        end
    end

    always_comb begin
        state_d      = state_q;
        paddr_d      = paddr_q;
        ash_d        = ash_q;
        acnt_d       = acnt_q;
        wcnt_d       = wcnt_q;
        rcnt_d       = rcnt_q;
        pwdata_d     = pwdata_q;
        rdata_d      = rdata_q;
        pwrite_d     = pwrite_q;
        addr_valid_d = addr_valid_q;
        abort_d      = abort_q;
        aborting     = abort_q | busy_fall;

        // Outside an APB access a stop ends the transfer at once
        if (busy_fall && state_q != S_SETUP && state_q != S_ACCESS) begin
            state_d      = S_IDLE;
            acnt_d       = '0;
            wcnt_d       = '0;
            rcnt_d       = '0;
            addr_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_fire) begin
                        ash_d        = AW8'(in_data);
                        acnt_d       = 8'd1;
                        addr_valid_d = 1'b0;
                        state_d      = S_ADDR;
                    end else if (out_ready) begin
                        pwrite_d = 1'b0;
                        state_d  = S_SETUP;
                    end
                end
                S_ADDR: begin
                    if (acnt_q == AB_C) begin
                        paddr_d      = ash_q[ADDR_WIDTH-1:0];
                        addr_valid_d = 1'b1;
                        wcnt_d       = '0;
                        state_d      = S_WDATA;
                    end else if (in_fire) begin
                        ash_d  = (ash_q << 8) | AW8'(in_data);
                        acnt_d = acnt_q + 8'd1;
                    end
                end
                S_WDATA: begin
                    if (in_fire) begin
                        for (int i = 0; i < DATA_BYTES; i++) begin
                            if (wcnt_q == 8'(i)) begin
                                pwdata_d[8*i +: 8] = in_data;
                            end
                        end
                        if (wcnt_q == DB_LAST) begin
                            wcnt_d   = '0;
                            pwrite_d = 1'b1;
                            state_d  = S_SETUP;
                        end else begin
                            wcnt_d = wcnt_q + 8'd1;
                        end
                    end else if (out_ready && wcnt_q == 8'd0) begin
                        pwrite_d = 1'b0;
                        state_d  = S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (busy_fall) begin
                        abort_d = 1'b1;
                    end
                    state_d = S_ACCESS;
                end
                S_ACCESS: begin
                    if (busy_fall) begin
                        abort_d = 1'b1;
                    end
                    if (PREADY) begin
                        abort_d = 1'b0;
                        // A dropped read leaves the address for a later re-read
                        if (AUTO_INC != 0 && (pwrite_q || !aborting)) begin
                            paddr_d = paddr_q + ADDR_WIDTH'(1);
                        end
                        if (aborting) begin
                            state_d      = S_IDLE;
                            acnt_d       = '0;
                            wcnt_d       = '0;
                            rcnt_d       = '0;
                            addr_valid_d = 1'b0;
                        end else if (pwrite_q) begin
                            state_d = S_WDATA;
                        end else begin
                            rdata_d = perr ? '1 : PRDATA;
                            rcnt_d  = '0;
                            state_d = S_RSEND;
                        end
                    end
                end
                S_RSEND: begin
                    if (out_ready) begin
                        if (rcnt_q == DB_LAST) begin
                            rcnt_d  = '0;
                            state_d = S_WDATA;
                        end else begin
                            rcnt_d = rcnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        out_data  = 8'h00;
        unique case (state_q)
            S_IDLE, S_WDATA: in_ready = ~rst;
            S_ADDR:          in_ready = ~rst & (acnt_q != AB_C);
            S_SETUP:         PSEL = 1'b1;
            S_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
            end
            S_RSEND:         out_valid = 1'b1;
            default: ;
        endcase
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (rcnt_q == 8'(i)) begin
                out_data = rdata_q[8*i +: 8];
            end
        end
    end

    assign PWRITE   = pwrite_q;
    assign PADDR    = paddr_q;
    assign PWDATA   = pwdata_q;
    assign out_last = 1'b0;

endmodule

// File: tb/tb_stream_bytes_to_apb.sv
// Directed plus randomized bench for stream_bytes_to_apb (8-bit address, 16-bit words).
// An APB slave model logs accesses; expected traffic is derived from the byte streams sent.
module tb_stream_bytes_to_apb;

    localparam int AW = 8;
    localparam int DB = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid, in_ready, in_last;
    logic [7:0]    out_data;
    logic          out_valid, out_ready, out_last;
    logic          busy;
    logic          PSEL, PENABLE, PWRITE, PREADY;
    logic [AW-1:0] PADDR;
    logic [15:0]   PWDATA, PRDATA;
    logic          err;
`ifdef STREAM_APB_PSLVERR_EN
    logic          PSLVERR;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] rmem [256];
    int          wait_cfg = 0;
    int          acc_cnt = 0;
    int          psel_run = 0;
    int          pen_run = 0;
    bit          rdy_viol = 1'b0;
    bit          err_inj = 1'b0;
    logic [24:0] log_q[$];
    logic [24:0] exp_q[$];
    int          psel_len_q[$];
    int          pen_len_q[$];
    logic [7:0]  wr_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  eb_q[$];

    always #5 clk = ~clk;

    assign PREADY = PSEL && PENABLE && (acc_cnt >= wait_cfg);
    assign PRDATA = rmem[PADDR];
`ifdef STREAM_APB_PSLVERR_EN
    assign PSLVERR = PREADY && err_inj;
`endif

    stream_bytes_to_apb #(.ADDR_WIDTH(AW), .DATA_BYTES(DB), .AUTO_INC(1)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
`ifdef STREAM_APB_PSLVERR_EN
        .PSLVERR(PSLVERR),
`endif
        .err(err)
    );

    // APB slave model: wait states, access log, phase lengths
    always @(posedge clk) begin
        if (rst) begin
            psel_run <= 0;
            pen_run  <= 0;
            acc_cnt  <= 0;
        end else begin
            acc_cnt <= (PSEL && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
            if (PSEL && in_ready) rdy_viol <= 1'b1;
            if (PSEL && PENABLE && PREADY) begin
                log_q.push_back({PWRITE, PADDR, PWRITE ? PWDATA : PRDATA});
                psel_len_q.push_back(psel_run + 1);
                pen_len_q.push_back(pen_run + 1);
                psel_run <= 0;
                pen_run  <= 0;
            end else begin
                psel_run <= PSEL ? psel_run + 1 : 0;
                pen_run  <= PENABLE ? pen_run + 1 : 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            cyc(1);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        cyc(1);
        in_valid = 1'b0;
    endtask

    task automatic settle();
        int q = 0;
        int t = 0;
        while (q < 2 && t < 300) begin
            cyc(1);
            t++;
            q = PSEL ? 0 : q + 1;
        end
        chk("settle", 32'(PSEL), 32'd0);
    endtask

    task automatic write_txn(input logic [7:0] a);
        busy = 1'b1;
        cyc(1);
        send_byte(a);
        foreach (wr_q[i]) send_byte(wr_q[i]);
        settle();
        busy = 1'b0;
        cyc(2);
        for (int i = 0; i < wr_q.size() / 2; i++)
            exp_q.push_back({1'b1, 8'(a + i), wr_q[2*i+1], wr_q[2*i]});
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_cnt"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_acc%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
        log_q.delete();
        exp_q.delete();
        psel_len_q.delete();
        pen_len_q.delete();
    endtask

    task automatic do_read(input int n, output int lat);
        int t = 0;
        lat = -1;
        rd_q.delete();
        out_ready = 1'b1;
        while (rd_q.size() < n && t < 400) begin
            if (out_valid) begin
                if (lat < 0) lat = t;
                rd_q.push_back(out_data);
            end
            cyc(1);
            t++;
        end
        out_ready = 1'b0;
        chk("read_count", 32'(rd_q.size()), 32'(n));
    endtask

    task automatic check_bytes(input string tag);
        for (int i = 0; i < rd_q.size() && i < eb_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), 32'(rd_q[i]), 32'(eb_q[i]));
        eb_q.delete();
    endtask

    initial begin
        int lat;
        int t;
        logic [7:0] a;
        int n;

        rst = 1'b1;
        in_data = 8'h00;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b0;
        busy = 1'b0;
        for (int i = 0; i < 256; i++) rmem[i] = 16'($urandom);
        rmem[8'h20] = 16'hBEEF;
        rmem[8'h21] = 16'hCAFE;
        cyc(3);

        chk("rst_psel", 32'(PSEL), 0);
        chk("rst_penable", 32'(PENABLE), 0);
        chk("rst_pwrite", 32'(PWRITE), 0);
        chk("rst_paddr", 32'(PADDR), 0);
        chk("rst_pwdata", 32'(PWDATA), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        cyc(1);
        chk("idle_in_ready", 32'(in_ready), 1);

        // Single word write with latency and phase-length checks
        busy = 1'b1;
        cyc(1);
        send_byte(8'h10);
        send_byte(8'h34);
        send_byte(8'h12);
        chk("lat_psel", 32'(PSEL), 1);
        chk("lat_pen0", 32'(PENABLE), 0);
        chk("lat_pwrite", 32'(PWRITE), 1);
        cyc(1);
        chk("lat_pen1", 32'(PENABLE), 1);
        cyc(1);
        chk("psel_drop", 32'(PSEL), 0);
        settle();
        busy = 1'b0;
        cyc(2);
        exp_q.push_back({1'b1, 8'h10, 16'h1234});
        if (psel_len_q.size() > 0) chk("t1_psel_len", 32'(psel_len_q[0]), 2);
        else chk("t1_psel_len_missing", 32'(psel_len_q.size()), 1);
        check_log("t1");
        chk("t1_paddr", 32'(PADDR), 32'h11);

        // Two words with auto-increment
        wr_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        write_txn(8'h10);
        check_log("t2");

        // Address write then repeated-start read of two words
        busy = 1'b1;
        cyc(1);
        send_byte(8'h20);
        cyc(1);
        do_read(4, lat);
        chk("read_latency", 32'(lat), 3);
        eb_q = '{8'hEF, 8'hBE, 8'hFE, 8'hCA};
        check_bytes("t3");
        busy = 1'b0;
        cyc(2);
        exp_q.push_back({1'b0, 8'h20, 16'hBEEF});
        exp_q.push_back({1'b0, 8'h21, 16'hCAFE});
        check_log("t3");
        chk("t3_paddr", 32'(PADDR), 32'h22);

        // Five wait states while the stream keeps pushing bytes
        wait_cfg = 5;
        wr_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        write_txn(8'h30);
        if (pen_len_q.size() > 0) begin
            chk("t4_pen_len", 32'(pen_len_q[0]), 6);
            chk("t4_psel_len", 32'(psel_len_q[0]), 7);
        end else chk("t4_len_missing", 32'(pen_len_q.size()), 1);
        check_log("t4");
        wait_cfg = 0;

        // Address wrap
        wr_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        write_txn(8'hFF);
        check_log("t5");
        chk("t5_paddr", 32'(PADDR), 32'h01);

        // Partial word dropped at stop, next transaction starts fresh
        busy = 1'b1;
        cyc(1);
        send_byte(8'h10);
        send_byte(8'h55);
        busy = 1'b0;
        cyc(3);
        chk("t6_no_access", 32'(log_q.size()), 0);
        chk("t6_in_ready", 32'(in_ready), 1);
        wr_q = '{8'h66, 8'h77};
        write_txn(8'h50);
        check_log("t6");

        // Random writes with random wait states
        for (int k = 0; k < 4; k++) begin
            a = 8'($urandom);
            n = $urandom_range(1, 3);
            wait_cfg = $urandom_range(0, 3);
            wr_q.delete();
            for (int j = 0; j < 2 * n; j++) wr_q.push_back(8'($urandom));
            write_txn(a);
            check_log($sformatf("rw%0d", k));
            chk($sformatf("rw%0d_paddr", k), 32'(PADDR), 32'(8'(a + n)));
        end
        wait_cfg = 0;

        // Random reads
        for (int k = 0; k < 3; k++) begin
            a = 8'($urandom);
            n = $urandom_range(1, 3);
            busy = 1'b1;
            cyc(1);
            send_byte(a);
            cyc(1);
            do_read(2 * n, lat);
            for (int j = 0; j < n; j++) begin
                eb_q.push_back(rmem[8'(a + j)][7:0]);
                eb_q.push_back(rmem[8'(a + j)][15:8]);
                exp_q.push_back({1'b0, 8'(a + j), rmem[8'(a + j)]});
            end
            check_bytes($sformatf("rr%0d", k));
            busy = 1'b0;
            cyc(2);
            check_log($sformatf("rr%0d", k));
        end

        // Reset in the middle of a stalled access
        wait_cfg = 20;
        busy = 1'b1;
        cyc(1);
        send_byte(8'h40);
        send_byte(8'h11);
        send_byte(8'h22);
        t = 0;
        while (!PENABLE && t < 50) begin
            cyc(1);
            t++;
        end
        chk("t8_in_access", 32'(PENABLE), 1);
        rst = 1'b1;
        cyc(1);
        chk("t8_psel", 32'(PSEL), 0);
        chk("t8_penable", 32'(PENABLE), 0);
        chk("t8_paddr", 32'(PADDR), 0);
        rst = 1'b0;
        busy = 1'b0;
        wait_cfg = 0;
        cyc(2);
        chk("t8_no_access", 32'(log_q.size()), 0);
        wr_q = '{8'h9A, 8'hBC};
        write_txn(8'h41);
        check_log("t8_after");

`ifdef STREAM_APB_PSLVERR_EN
        err_inj = 1'b1;
        busy = 1'b1;
        cyc(1);
        send_byte(8'h60);
        cyc(1);
        do_read(2, lat);
        eb_q = '{8'hFF, 8'hFF};
        check_bytes("perr");
        chk("perr_err_set", 32'(err), 1);
        busy = 1'b0;
        err_inj = 1'b0;
        cyc(2);
        busy = 1'b1;
        cyc(1);
        send_byte(8'h61);
        chk("perr_err_clear", 32'(err), 0);
        busy = 1'b0;
        cyc(3);
        log_q.delete();
        psel_len_q.delete();
        pen_len_q.delete();
`endif

        chk("ready_during_apb", 32'(rdy_viol), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
